// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the dual-clock FIFO pointer blocks (write and read side).
//   ptr_width   : pointer width for a given RAM address width (one extra wrap bit)
//   gray_encode : binary to reflected Gray code
//   full_target : the Gray value the write pointer must equal for the FIFO to be
//                 full, given the synchronized read pointer (top two bits inverted)
// The functions work on 32-bit containers so that blocks of any pointer width
// can share them; callers zero-extend on the way in and size-cast on the way out.
// ----------------------------------------------------------------------------
package fifo_pkg;

    function automatic int ptr_width(input int asize);
        return asize + 1;
    endfunction

    function automatic logic [31:0] gray_encode(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // In Gray code, a pointer exactly one full lap ahead of another differs in
    // its two most significant bits and matches in all the others.
    function automatic logic [31:0] full_target(input logic [31:0] gray, input int w);
        return gray ^ (32'h3 << (w - 2));
    endfunction

endpackage

// File: rtl/gray2bin.sv
// ----------------------------------------------------------------------------
// gray2bin
// Combinational Gray to binary converter (prefix XOR from the MSB downwards).
// Ports:
//   gray_i  [W-1:0]  Gray-coded input
//   bin_o   [W-1:0]  binary equivalent
// ----------------------------------------------------------------------------
module gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[W-1:i];
    end

endmodule

// File: rtl/wptr_full.sv
// ----------------------------------------------------------------------------
// wptr_full
// Write-side pointer and full-flag generator for the dual-clock FIFO. Keeps the
// binary write count, publishes a Gray write pointer to the read domain, brings
// the read domain's Gray pointer across with a two-flop synchronizer and derives
// registered full, sticky overflow and (optionally) almost-full flags.
//
// Optional feature: define WPTR_FULL_AFULL_EN to build the almost-full logic.
// Without it walmost_full is tied low; the port list is the same either way.
//
// Ports:
//   wclk          in   write clock, all state updates on its rising edge
//   wrst          in   synchronous active-high reset
//   winc          in   write request for this cycle
//   rptr          in   [ASIZE:0] Gray read pointer, asynchronous to wclk
//   waddr         out  [ASIZE-1:0] RAM write address
//   wptr          out  [ASIZE:0] registered Gray write pointer
//   wfull         out  registered full flag
//   wovf          out  sticky overflow (write attempted while full)
//   walmost_full  out  almost-full flag
// ----------------------------------------------------------------------------
module wptr_full
    import fifo_pkg::*;
#(
    parameter int ASIZE        = 4,
    parameter int AFULL_MARGIN = 2
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             winc,
    input  logic [ASIZE:0]   rptr,
    output logic [ASIZE-1:0] waddr,
    output logic [ASIZE:0]   wptr,
    output logic             wfull,
    output logic             wovf,
    output logic             walmost_full
);

    localparam int PW = ptr_width(ASIZE);

    logic [PW-1:0] wbin_q,     wbin_d;
    logic [PW-1:0] wptr_q,     wptr_d;
    logic [PW-1:0] wq1Rptr_q;
    logic [PW-1:0] wq2Rptr_q;
    logic          wfull_q,    wfull_d;
    logic          wovf_q,     wovf_d;

    // Next pointer values and flags. A write only advances the count when the
    // FIFO is not already full; a refused write sets the sticky overflow flag.
    // Full is judged on the pointer we are about to register, so the flag rises
    // on the same edge that accepts the write into the last free entry.
    always_comb begin
        wbin_d  = wbin_q + PW'(winc & ~wfull_q);
        wptr_d  = PW'(gray_encode(32'(wbin_d)));
        wfull_d = (32'(wptr_d) == full_target(32'(wq2Rptr_q), PW));
        wovf_d  = wovf_q | (winc & wfull_q);
    end

    // Pointer, flag and synchronizer registers. rptr is only ever sampled by
    // wq1Rptr_q; everything else works from the second stage.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q    <= '0;
            wptr_q    <= '0;
            wq1Rptr_q <= '0;
            wq2Rptr_q <= '0;
            wfull_q   <= 1'b0;
            wovf_q    <= 1'b0;
        end else begin
            wbin_q    <= wbin_d;
            wptr_q    <= wptr_d;
            wq1Rptr_q <= rptr;
            wq2Rptr_q <= wq1Rptr_q;
            wfull_q   <= wfull_d;
            wovf_q    <= wovf_d;
        end
    end

`ifdef WPTR_FULL_AFULL_EN
    localparam logic [PW-1:0] AFULL_THRESH = PW'((1 << ASIZE) - AFULL_MARGIN);

    logic [PW-1:0] rbinS;
    logic [PW-1:0] wlevel;
    logic          wafull_q, wafull_d;

    gray2bin #(
        .W (PW)
    ) u_gray2bin (
        .gray_i (wq2Rptr_q),
        .bin_o  (rbinS)
    );

    // Occupancy as seen from the write side. The read pointer is stale by the
    // synchronizer latency, so the level only ever over-estimates; a full FIFO
    // reads as 2**ASIZE and therefore keeps the flag high.
    always_comb begin
        wlevel   = wbin_d - rbinS;
        wafull_d = (wlevel >= AFULL_THRESH);
    end

    // Registered almost-full flag.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wafull_q <= 1'b0;
        end else begin
            wafull_q <= wafull_d;
        end
    end

    assign walmost_full = wafull_q;
`else
    assign walmost_full = 1'b0;
`endif

    assign waddr = wbin_q[ASIZE-1:0];
    assign wptr  = wptr_q;
    assign wfull = wfull_q;
    assign wovf  = wovf_q;

endmodule
